rand_digit_gen: RTL and testbench

//  Parametrised LFSR random-number source with unbiased reduction to [0, RANGE-1]
//  by rejection sampling, buffered in a small output FIFO with a valid/ready handshake.

---
 rtl/rand_pkg.sv | 37 +++
 rtl/rand_fifo.sv | 84 ++++++++
 rtl/rand_digit_gen.sv | 113 +++++++++++
 tb/tb_rand_digit_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// -----------------------------------------------------------------------------
// rand_pkg
//   Shared constants and helpers for the random digit generator.
//   - RANDGEN_* : default parameter values for rand_digit_gen
//   - clog2     : ceiling log2, usable in constant expressions
//   - galois_next : one Galois LFSR step on a 32-bit container; callers
//                   zero-extend narrower states/taps and truncate the result.
// -----------------------------------------------------------------------------
package rand_pkg;

  localparam int          RANDGEN_WIDTH = 16;
  localparam logic [15:0] RANDGEN_TAPS  = 16'hB400;
  localparam logic [15:0] RANDGEN_SEED  = 16'hFFFF;
  localparam longint      RANDGEN_RANGE = 10;
  localparam int          RANDGEN_DEPTH = 4;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input longint value);
    int result;
    result = 0;
    for (int i = 0; i < 62; i++) begin
      if ((longint'(1) << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Galois step: shift right, fold the taps in when a 1 falls off the end.
  // A nonzero state never maps to zero.
  function automatic logic [31:0] galois_next(input logic [31:0] state,
                                              input logic [31:0] taps);
    logic [31:0] nxt;
    nxt = state >> 1;
    if (state[0]) nxt = nxt ^ taps;
    return nxt;
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// -----------------------------------------------------------------------------
// rand_fifo
//   Small synchronous FIFO with a registered head output and fill counter.
//   Ports:
//     clk, reset_n   clock / asynchronous active-low reset
//     flush          empties the FIFO (wins over push and pop)
//     push, push_data write one entry (ignored when full with no pop)
//     pop            removes the head (ignored when empty)
//     valid          head holds a real entry
//     head           head value; holds its last value while empty, 0 after reset
//     fill           number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module rand_fifo
  import rand_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 4,
  localparam int PTR_W  = clog2(longint'(DEPTH)),
  localparam int FILL_W = clog2(longint'(DEPTH + 1))
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [FILL_W-1:0] fill
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              pop_eff, push_eff;

  always_comb begin
    pop_eff  = pop & (count_q != '0);
    push_eff = push & ((count_q != FILL_W'(DEPTH)) | pop_eff);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_eff);
    count_d  = count_q + FILL_W'(push_eff) - FILL_W'(pop_eff);
    head_d   = head_q;
    // Pre-compute the head for the next cycle. The write pointer can only
    // coincide with the new read pointer on a push when the pushed entry is
    // the only one left, so it must bypass the array.
    if (count_d != '0) begin
      if (push_eff && (wr_ptr_q == rd_ptr_d)) head_d = push_data;
      else                                    head_d = mem[rd_ptr_d];
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      head_d   = head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign valid = (count_q != '0);
  assign head  = head_q;
  assign fill  = count_q;

endmodule

// File: rtl/rand_digit_gen.sv
// -----------------------------------------------------------------------------
// rand_digit_gen
//   Galois LFSR random source reduced to [0, RANGE-1] by rejection sampling,
//   buffered in a DEPTH-entry FIFO with a valid/ready output handshake.
//   The LFSR stalls (never drops) when the FIFO is full, so the value stream
//   is a fixed function of SEED regardless of consumer timing.
//   Ports:
//     clk         rising-edge clock
//     reset_n     asynchronous active-low reset (state <= SEED, FIFO empty)
//     stop        1 = freeze LFSR; queued values can still be popped
//     rand_ready  consumer takes rand_num this cycle
//     rand_valid  FIFO head valid
//     rand_num    FIFO head value (< RANGE when rand_valid)
//     fill        entries currently held
//     seed_load   synchronous reseed + FIFO flush   (RANDGEN_SEED_LOAD_EN only)
//     seed_val    new state, 0 selects SEED          (RANDGEN_SEED_LOAD_EN only)
//   Optional feature macro: RANDGEN_SEED_LOAD_EN (adds seed_load/seed_val).
// -----------------------------------------------------------------------------
module rand_digit_gen
  import rand_pkg::*;
#(
  parameter  int               WIDTH  = RANDGEN_WIDTH,
  parameter  logic [WIDTH-1:0] TAPS   = RANDGEN_TAPS,
  parameter  logic [WIDTH-1:0] SEED   = RANDGEN_SEED,
  parameter  longint           RANGE  = RANDGEN_RANGE,
  parameter  int               DEPTH  = RANDGEN_DEPTH,
  localparam int               OUT_W  = clog2(RANGE),
  localparam int               FILL_W = clog2(longint'(DEPTH + 1))
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stop,
  input  logic              rand_ready,
  output logic              rand_valid,
  output logic [OUT_W-1:0]  rand_num,
  output logic [FILL_W-1:0] fill
`ifdef RANDGEN_SEED_LOAD_EN
  ,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_val
`endif
);

  // Elaboration-time parameter checks.
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("rand_digit_gen: WIDTH must be 4..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("rand_digit_gen: SEED must be nonzero");
  end
  if (RANGE < 2 || RANGE > (longint'(1) << WIDTH)) begin : g_bad_range
    $error("rand_digit_gen: RANGE must be 2..2**WIDTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rand_digit_gen: DEPTH must be a power of 2, >= 2");
  end

  // One extra bit so a power-of-2 RANGE compares as "always below".
  localparam logic [OUT_W:0] RANGE_V = (OUT_W + 1)'(RANGE);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] load_val;
  logic [OUT_W-1:0] cand;
  logic             load;
  logic             full, pop, adv, accept, push;

  always_comb begin
    load     = 1'b0;
    load_val = SEED;
`ifdef RANDGEN_SEED_LOAD_EN
    load = seed_load;
    if (seed_val != '0) load_val = seed_val;
`endif
  end

  assign lfsr_next = WIDTH'(galois_next(32'(state_q), 32'(TAPS)));
  assign cand      = state_q[OUT_W-1:0];
  assign accept    = ({1'b0, cand} < RANGE_V);

  // A reseed owns the cycle: no draw, push or pop alongside it.
  assign full = (fill == FILL_W'(DEPTH));
  assign pop  = rand_valid & rand_ready & ~load;
  assign adv  = ~stop & (~full | pop) & ~load;
  assign push = adv & accept;

  always_comb begin
    state_d = state_q;
    if (load)     state_d = load_val;
    else if (adv) state_d = lfsr_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  rand_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (load),
    .push      (push),
    .push_data (cand),
    .pop       (pop),
    .valid     (rand_valid),
    .head      (rand_num),
    .fill      (fill)
  );

endmodule

// File: tb/tb_rand_digit_gen.sv
// -----------------------------------------------------------------------------
// tb_rand_digit_gen
//   Scoreboard bench: the expected value stream is queued from an LFSR model
//   and popped by a monitor whenever the DUT hands over a value; directed
//   checks cover reset, latency, stall, stop, async reset and reseed.
// -----------------------------------------------------------------------------
module tb_rand_digit_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (defaults: RANGE=10, DEPTH=4)
  logic       reset_n, stop, rand_ready;
  logic       rand_valid;
  logic [3:0] rand_num;
  logic [2:0] fill;
`ifdef RANDGEN_SEED_LOAD_EN
  logic        seed_load;
  logic [15:0] seed_val;
`endif

  // Second DUT with RANGE=16: every draw is accepted.
  logic       reset16_n;
  logic       v16;
  logic [3:0] n16;
  logic [2:0] f16;
  logic       done16;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int exp16_q[$];

  rand_digit_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stop       (stop),
    .rand_ready (rand_ready),
    .rand_valid (rand_valid),
    .rand_num   (rand_num),
    .fill       (fill)
`ifdef RANDGEN_SEED_LOAD_EN
    ,
    .seed_load  (seed_load),
    .seed_val   (seed_val)
`endif
  );

  rand_digit_gen #(.RANGE(16)) dut16 (
    .clk        (clk),
    .reset_n    (reset16_n),
    .stop       (1'b0),
    .rand_ready (1'b1),
    .rand_valid (v16),
    .rand_num   (n16),
    .fill       (f16)
`ifdef RANDGEN_SEED_LOAD_EN
    ,
    .seed_load  (1'b0),
    .seed_val   (16'h0000)
`endif
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s: %0d (t=%0t)", name, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepted-value stream (RANGE=10) starting from state s0.
  task automatic load_expected(input logic [15:0] s0);
    logic [15:0] s;
    exp_q.delete();
    s = s0;
    while (exp_q.size() < 200) begin
      if (s[3:0] < 4'd10) exp_q.push_back(int'(s[3:0]));
      s = lfsr_step(s);
    end
  endtask

  task automatic wait_fill(input int target, input string name);
    int k;
    k = 0;
    while (fill != 3'(target) && k < 200) begin
      tick();
      k++;
    end
    check(name, 32'(fill), 32'(target));
  endtask

  // From a freshly restarted FFFF state: eight rejected draws, then 7.
  task automatic check_first_draw(input string tag);
    repeat (8) tick();
    check({tag, "_valid_after8"}, 32'(rand_valid), 32'd0);
    tick();
    check({tag, "_valid_after9"}, 32'(rand_valid), 32'd1);
    check({tag, "_num_after9"},   32'(rand_num),   32'd7);
    check({tag, "_fill_after9"},  32'(fill),       32'd1);
  endtask

  // Monitor: a handover happens at the next rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rand_valid === 1'b1 && rand_ready === 1'b1
`ifdef RANDGEN_SEED_LOAD_EN
        && seed_load !== 1'b1
`endif
       ) begin
      if (exp_q.size() == 0) check("pop_underflow", 32'(rand_num), 32'hFFFF_FFFF);
      else                   check("pop", 32'(rand_num), exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset16_n === 1'b1 && v16 === 1'b1) begin
      if (exp16_q.size() == 0) check("pop16_underflow", 32'(n16), 32'hFFFF_FFFF);
      else                     check("pop16", 32'(n16), exp16_q.pop_front());
    end
  end

  // RANGE=16 instance: rand_num must be the low nibble of each drawn state.
  initial begin
    logic [15:0] s;
    done16    = 1'b0;
    reset16_n = 1'b0;
    s = 16'hFFFF;
    for (int i = 0; i < 100; i++) begin
      exp16_q.push_back(int'(s[3:0]));
      s = lfsr_step(s);
    end
    repeat (3) tick();
    reset16_n = 1'b1;
    repeat (60) tick();
    // push and pop every cycle keeps exactly one entry
    check("r16_fill_steady", 32'(f16), 32'd1);
    check("r16_valid_steady", 32'(v16), 32'd1);
    reset16_n = 1'b0;
    #1;
    check("r16_reset_fill", 32'(f16), 32'd0);
    done16 = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_n    = 1'b0;
    stop       = 1'b0;
    rand_ready = 1'b0;
`ifdef RANDGEN_SEED_LOAD_EN
    seed_load  = 1'b0;
    seed_val   = 16'h0000;
`endif
    load_expected(16'hFFFF);
    repeat (2) tick();

    // Reset state
    check("rst_valid", 32'(rand_valid), 32'd0);
    check("rst_num",   32'(rand_num),   32'd0);
    check("rst_fill",  32'(fill),       32'd0);

    // Test 1: first accepted value is 7 on the 9th draw
    reset_n = 1'b1;
    check_first_draw("t1");

    // Test 2: full FIFO stalls; one pop while the next candidate (2) is
    // accepted keeps fill at 4 and advances the head to 3.
    wait_fill(4, "t2_fill_full");
    repeat (5) tick();
    check("t2_fill_stall", 32'(fill),     32'd4);
    check("t2_num_stable", 32'(rand_num), 32'd7);
    rand_ready = 1'b1;
    tick();
    rand_ready = 1'b0;
    check("t2_fill_after_pop", 32'(fill),     32'd4);
    check("t2_head_after_pop", 32'(rand_num), 32'd3);

    // Test 3: stop, drain 3,9 then 4,2; state frozen; resume continues stream
    stop       = 1'b1;
    rand_ready = 1'b1;
    repeat (2) tick();
    check("t3_fill_2", 32'(fill), 32'd2);
    repeat (2) tick();
    check("t3_valid_drained", 32'(rand_valid), 32'd0);
    check("t3_fill_drained",  32'(fill),       32'd0);
    check("t3_num_holds",     32'(rand_num),   32'd2);
    repeat (3) tick();
    check("t3_fill_frozen", 32'(fill), 32'd0);
    stop = 1'b0;
    repeat (30) tick();
    rand_ready = 1'b0;

    // Test 4: asynchronous reset mid-stream, then replay of test 1
    wait_fill(3, "t4_fill_3");
    reset_n = 1'b0;
    load_expected(16'hFFFF);
    #1;
    check("t4_rst_fill",  32'(fill),       32'd0);
    check("t4_rst_valid", 32'(rand_valid), 32'd0);
    check("t4_rst_num",   32'(rand_num),   32'd0);
    tick();
    reset_n = 1'b1;
    check_first_draw("t4");

`ifdef RANDGEN_SEED_LOAD_EN
    // Test 6: reseed with 0 selects SEED; reseed with 1 gives 1 then 0 (B400)
    wait_fill(2, "t6_fill_2");
    seed_load = 1'b1;
    seed_val  = 16'h0000;
    load_expected(16'hFFFF);
    tick();
    seed_load = 1'b0;
    check("t6_flush_fill",  32'(fill),       32'd0);
    check("t6_flush_valid", 32'(rand_valid), 32'd0);
    check_first_draw("t6");
    seed_load = 1'b1;
    seed_val  = 16'h0001;
    load_expected(16'h0001);
    tick();
    seed_load = 1'b0;
    check("t6_load1_fill", 32'(fill), 32'd0);
    tick();
    check("t6_load1_num", 32'(rand_num), 32'd1);
    tick();
    check("t6_load1_fill2", 32'(fill), 32'd2);
    rand_ready = 1'b1;
    repeat (20) tick();
    rand_ready = 1'b0;
`endif

    k = 0;
    while (!done16 && k < 500) begin
      tick();
      k++;
    end
    check("r16_done", 32'(done16), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
